aes_stream_top: RTL

- Streaming wrapper around the fixed-latency pipelined aes_128 core. Adds valid/ready handshakes on input and output, a per-block tag, and an output FIFO with credit-based admission, so downstream backpressure never drops a ciphertext.
- Successor to the bare core-instantiation top: parametrised core latency, FIFO depth and tag width.
- Sits between the host/stimulus interface and any consumer of ciphertext.

---
 rtl/aes_stream_top.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/aes_stream_top.sv
// Streaming AES-128 encryptor: valid/ready input, per-block tag, credit-guarded FWFT output FIFO.
// Optional feature macro STREAM_PERF_CNT_EN adds blk_in_cnt / blk_out_cnt / stall_cnt ports.

module aes_stream_top #(
    parameter int CORE_LATENCY = 21,
    parameter int FIFO_DEPTH   = 32,
    parameter int TAG_W        = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [127:0]       in_state,
    input  logic [127:0]       in_key,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [127:0]       out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               busy
`ifdef STREAM_PERF_CNT_EN
    ,
    output logic [31:0]        blk_in_cnt,
    output logic [31:0]        blk_out_cnt,
    output logic [31:0]        stall_cnt
`endif
);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam int EW  = TAG_W + 1;
    localparam int DLW = CORE_LATENCY * EW;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [PW-1:0] PONE_C  = PW'(1);

    logic [CW-1:0]        credits_r;
    logic [CW-1:0]        count_r;
    logic [PW-1:0]        wr_ptr_r;
    logic [PW-1:0]        rd_ptr_r;
    logic [TAG_W+127:0]   mem_r [FIFO_DEPTH];
    logic [DLW-1:0]       dl_r;
    logic [EW-1:0]        tail_s;
    logic [127:0]         core_out_s;
    logic [TAG_W+127:0]   head_s;
    logic                 accept_s;
    logic                 pop_s;
    logic                 wr_s;

    assign in_ready  = (credits_r != {CW{1'b0}});
    assign accept_s  = in_valid & in_ready;
    assign out_valid = (count_r != {CW{1'b0}});
    assign pop_s     = out_valid & out_ready;
    assign busy      = (credits_r != DEPTH_C);
    assign tail_s    = dl_r[DLW-1 -: EW];
    assign wr_s      = tail_s[EW-1];
    assign head_s    = mem_r[rd_ptr_r];
    assign out_data  = out_valid ? head_s[127:0] : 128'h0;
    assign out_tag   = out_valid ? head_s[TAG_W+127:128] : {TAG_W{1'b0}};

    aes_128 #(.LATENCY(CORE_LATENCY)) u_core (
        .clk   (clk),
        .state (in_state),
        .key   (in_key),
        .out   (core_out_s)
    );

    // One credit per FIFO slot: an accept reserves a slot, a pop returns it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credits_r <= DEPTH_C;
        end else begin
            case ({accept_s, pop_s})
                2'b10:   credits_r <= credits_r - ONE_C;
                2'b01:   credits_r <= credits_r + ONE_C;
                default: credits_r <= credits_r;
            endcase
        end
    end

    // Valid/tag delay line matching the core latency; oldest entry sits at the top.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dl_r <= {DLW{1'b0}};
        end else begin
            dl_r <= DLW'({dl_r, accept_s, in_tag});
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            wr_ptr_r <= wr_s  ? wr_ptr_r + PONE_C : wr_ptr_r;
            rd_ptr_r <= pop_s ? rd_ptr_r + PONE_C : rd_ptr_r;
            case ({wr_s, pop_s})
                2'b10:   count_r <= count_r + ONE_C;
                2'b01:   count_r <= count_r - ONE_C;
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage, intentionally left unreset.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[wr_ptr_r] <= {tail_s[TAG_W-1:0], core_out_s};
        end
    end

`ifdef STREAM_PERF_CNT_EN
    // Free-running event counters, wrapping modulo 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blk_in_cnt  <= 32'd0;
            blk_out_cnt <= 32'd0;
            stall_cnt   <= 32'd0;
        end else begin
            blk_in_cnt  <= accept_s ? blk_in_cnt + 32'd1 : blk_in_cnt;
            blk_out_cnt <= pop_s ? blk_out_cnt + 32'd1 : blk_out_cnt;
            stall_cnt   <= (in_valid && !in_ready) ? stall_cnt + 32'd1 : stall_cnt;
        end
    end
`endif

    aes_stream_chk #(.FIFO_DEPTH(FIFO_DEPTH), .CW(CW)) u_chk (
        .clk     (clk),
        .rst     (rst),
        .credits (credits_r),
        .count   (count_r),
        .accept  (accept_s),
        .wr      (wr_s)
    );
endmodule

// AES-128 encrypt core: full cipher on entry, result carried through LATENCY register stages.
module aes_128 #(
    parameter int LATENCY = 21
) (
    input  logic         clk,
    input  logic [127:0] state,
    input  logic [127:0] key,
    output logic [127:0] out
);
    localparam int PLW = LATENCY * 128;

    logic [PLW-1:0] pipe_r;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            acc = acc ^ (b[i] ? p : 8'h00);
            p   = xtime(p);
        end
        return acc;
    endfunction

    // S-box computed as x^254 (GF(2^8) inverse) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [127:0] k);
        logic [127:0] s;
        logic [127:0] rk;
        logic [7:0]   rc;
        s  = pt ^ k;
        rk = k;
        rc = 8'h01;
        for (int rnd = 1; rnd <= 10; rnd++) begin
            rk = next_key(rk, rc);
            rc = xtime(rc);
            s  = sub_shift(s);
            s  = (rnd == 10) ? s : mix_cols(s);
            s  = s ^ rk;
        end
        return s;
    endfunction

    // Result pipeline; the oldest stage sits at the top of the packed vector.
    always_ff @(posedge clk) begin
        pipe_r <= PLW'({pipe_r, aes_encrypt(state, key)});
    end

    assign out = pipe_r[PLW-1 -: 128];
endmodule

// Credit and FIFO invariants for the streaming wrapper.
module aes_stream_chk #(
    parameter int FIFO_DEPTH = 32,
    parameter int CW         = 6
) (
    input logic          clk,
    input logic          rst,
    input logic [CW-1:0] credits,
    input logic [CW-1:0] count,
    input logic          accept,
    input logic          wr
);
    a_credit_max: assert property (@(posedge clk) disable iff (!rst)
        credits <= CW'(FIFO_DEPTH));
    a_credit_underflow: assert property (@(posedge clk) disable iff (!rst)
        !(accept && credits == {CW{1'b0}}));
    a_write_full: assert property (@(posedge clk) disable iff (!rst)
        !(wr && count == CW'(FIFO_DEPTH)));
endmodule
